// File: rtl/uart_pkg.sv
// Shared UART definitions: TX scheduler state encoding and an index-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_NEXT      = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_e;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((33'd1 << w) < 33'(value)) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping to 0.
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    assign any = |req;

    // Walk from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        idx = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req[IDX_W'((int'(rr_ptr) + k) % int'(N_REQ))]) begin
                idx = IDX_W'((int'(rr_ptr) + k) % int'(N_REQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX core among N_REQ byte-stream requesters with packet-locked
// round-robin arbitration, an inter-packet gap and a stalled-lock timeout.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned WORD_LEN     = 8,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WORD_LEN-1:0]  req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_start,
    output logic [WORD_LEN-1:0]        tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [clog2(N_REQ)-1:0]    grant_id,
    output logic                       locked,
    output logic                       abort_err
);

    localparam int unsigned IDX_W   = clog2(N_REQ);
    localparam int unsigned CNT_MAX = (GAP_CYCLES > LOCK_TIMEOUT) ? GAP_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    sched_state_e         state, state_d;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]     grant_d, pick_idx, ptr_inc;
    logic                 pick_any;
    logic                 locked_d, last_q, last_d, start_d, abort_d;
    logic [N_REQ-1:0]     ready_d;
    logic [WORD_LEN-1:0]  data_d, sel_data;
    logic                 sel_valid, sel_last;
    logic [CNT_W-1:0]     cnt, cnt_d;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Granted requester's byte, valid and last flags.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_data = req_data[i*WORD_LEN +: WORD_LEN];
            end
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign ptr_inc   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        grant_d  = grant_id;
        locked_d = locked;
        last_d   = last_q;
        cnt_d    = cnt;
        ready_d  = '0;
        start_d  = 1'b0;
        data_d   = tx_data;
        abort_d  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_idx;
                    locked_d = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!tx_busy && sel_valid) begin
                    start_d = 1'b1;
                    data_d  = sel_data;
                    ready_d = N_REQ'(1) << grant_id;
                    last_d  = sel_last;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    cnt_d = '0;
                    if (last_q) begin
                        locked_d = 1'b0;
                        rr_ptr_d = ptr_inc;
                        state_d  = ST_GAP;
                    end else begin
                        state_d  = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (sel_valid) begin
                    state_d = ST_LOAD;
                end else if (cnt == TMO_LAST) begin
                    abort_d  = 1'b1;
                    locked_d = 1'b0;
                    rr_ptr_d = ptr_inc;
                    cnt_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // A zero gap still spends one cycle here.
                if ((GAP_CYCLES == 0) || (cnt == GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            locked    <= 1'b0;
            last_q    <= 1'b0;
            cnt       <= '0;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            abort_err <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant_id  <= grant_d;
            locked    <= locked_d;
            last_q    <= last_d;
            cnt       <= cnt_d;
            req_ready <= ready_d;
            tx_start  <= start_d;
            tx_data   <= data_d;
            abort_err <= abort_d;
        end
    end

endmodule
